gnrl_idxdcdr128_module: RTL and testbench

Registered 128-entry occupancy map driven by index-encoded requests: the decode-side counterpart of the 128-bit priority encoder. Allocate and release requests carry a 7-bit index that is one-hot decoded into set/clear masks. The module maintains the map, an occupancy count, full/empty flags and a round-robin start pointer. Its `o_idx_map` and `o_idx_start` feed the priority encoder's map and start inputs directly, closing the select → allocate loop in the issue/rename-style free lists.

---
 rtl/gnrl_idxdcdr128_module.sv | 86 ++++++++
 tb/tb_gnrl_idxdcdr128_module.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/gnrl_idxdcdr128_module.sv
// 128-entry occupancy map updated by index-encoded alloc/free requests.
// Keeps an incremental count, full/empty flags and a round-robin start pointer.
module gnrl_idxdcdr128_module (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_idx_flush,
   input  logic         i_idx_alloc_vld,
   input  logic [6:0]   i_idx_alloc_idx,
   input  logic         i_idx_free_vld,
   input  logic [6:0]   i_idx_free_idx,
   output logic [127:0] o_idx_map,
   output logic [7:0]   o_idx_count,
   output logic         o_idx_full,
   output logic         o_idx_empty,
   output logic [6:0]   o_idx_start,
   output logic         o_idx_alloc_err,
   output logic         o_idx_free_err
);

   logic [127:0] map_q, map_d;
   logic [7:0]   count_q, count_d;
   logic         full_q, full_d;
   logic         empty_q, empty_d;
   logic [6:0]   start_q, start_d;
   logic         alloc_err_q, alloc_err_d;
   logic         free_err_q, free_err_d;

   logic [127:0] set_mask, clr_mask, map_mid;
   logic         alloc_ok, free_ok;

   always_comb begin
      set_mask = i_idx_alloc_vld ? (128'd1 << i_idx_alloc_idx) : '0;
      clr_mask = i_idx_free_vld  ? (128'd1 << i_idx_free_idx)  : '0;

      // Free is applied before alloc, so a same-index pair on a set bit is legal.
      map_mid     = map_q & ~clr_mask;
      free_err_d  = i_idx_free_vld & ~map_q[i_idx_free_idx];
      alloc_err_d = i_idx_alloc_vld & map_mid[i_idx_alloc_idx];
      free_ok     = i_idx_free_vld & ~free_err_d;
      alloc_ok    = i_idx_alloc_vld & ~alloc_err_d;

      map_d   = map_mid | set_mask;
      count_d = count_q - {7'd0, free_ok} + {7'd0, alloc_ok};
      start_d = alloc_ok ? i_idx_alloc_idx + 7'd1 : start_q;

      if (i_idx_flush) begin
         map_d       = '0;
         count_d     = '0;
         start_d     = '0;
         alloc_err_d = 1'b0;
         free_err_d  = 1'b0;
      end

      full_d  = (count_d == 8'd128);
      empty_d = (count_d == 8'd0);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         map_q       <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         start_q     <= '0;
         alloc_err_q <= 1'b0;
         free_err_q  <= 1'b0;
      end else begin
         map_q       <= map_d;
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         start_q     <= start_d;
         alloc_err_q <= alloc_err_d;
         free_err_q  <= free_err_d;
      end
   end

   assign o_idx_map       = map_q;
   assign o_idx_count     = count_q;
   assign o_idx_full      = full_q;
   assign o_idx_empty     = empty_q;
   assign o_idx_start     = start_q;
   assign o_idx_alloc_err = alloc_err_q;
   assign o_idx_free_err  = free_err_q;

endmodule

// File: tb/tb_gnrl_idxdcdr128_module.sv
// Scoreboard bench: driver pushes model expectations, monitor pops and compares each cycle.
module tb_gnrl_idxdcdr128_module;

   logic         i_clk = 1'b0;
   logic         i_rst = 1'b0;
   logic         i_idx_flush = 1'b0;
   logic         i_idx_alloc_vld = 1'b0;
   logic [6:0]   i_idx_alloc_idx = '0;
   logic         i_idx_free_vld = 1'b0;
   logic [6:0]   i_idx_free_idx = '0;
   logic [127:0] o_idx_map;
   logic [7:0]   o_idx_count;
   logic         o_idx_full;
   logic         o_idx_empty;
   logic [6:0]   o_idx_start;
   logic         o_idx_alloc_err;
   logic         o_idx_free_err;

   gnrl_idxdcdr128_module dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_idx_flush     (i_idx_flush),
      .i_idx_alloc_vld (i_idx_alloc_vld),
      .i_idx_alloc_idx (i_idx_alloc_idx),
      .i_idx_free_vld  (i_idx_free_vld),
      .i_idx_free_idx  (i_idx_free_idx),
      .o_idx_map       (o_idx_map),
      .o_idx_count     (o_idx_count),
      .o_idx_full      (o_idx_full),
      .o_idx_empty     (o_idx_empty),
      .o_idx_start     (o_idx_start),
      .o_idx_alloc_err (o_idx_alloc_err),
      .o_idx_free_err  (o_idx_free_err)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [127:0] map;
      logic [7:0]   cnt;
      logic         full;
      logic         empty;
      logic [6:0]   start;
      logic         aerr;
      logic         ferr;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: an array of occupied flags plus a start pointer.
   bit mm[128];
   int mstart = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input bit rst, input bit flush, input bit av, input int ai,
                       input bit fv, input int fi);
      exp_t e;
      int   n;
      @(negedge i_clk);
      i_rst           = rst;
      i_idx_flush     = flush;
      i_idx_alloc_vld = av;
      i_idx_alloc_idx = 7'(ai);
      i_idx_free_vld  = fv;
      i_idx_free_idx  = 7'(fi);
      e = '0;
      if (rst || flush) begin
         foreach (mm[k]) mm[k] = 1'b0;
         mstart = 0;
      end else begin
         if (fv && !mm[fi]) e.ferr = 1'b1;
         if (fv) mm[fi] = 1'b0;
         if (av && mm[ai]) e.aerr = 1'b1;
         else if (av) begin
            mm[ai] = 1'b1;
            mstart = (ai + 1) % 128;
         end
      end
      n = 0;
      for (int k = 0; k < 128; k++) begin
         e.map[k] = mm[k];
         n += int'(mm[k]);
      end
      e.cnt   = 8'(n);
      e.full  = (n == 128);
      e.empty = (n == 0);
      e.start = 7'(mstart);
      sb.push_back(e);
   endtask

   // Monitor: every cycle is an output cycle; compare just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge i_clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("map",       o_idx_map,                e.map);
            chk("count",     {120'd0, o_idx_count},    {120'd0, e.cnt});
            chk("full",      {127'd0, o_idx_full},     {127'd0, e.full});
            chk("empty",     {127'd0, o_idx_empty},    {127'd0, e.empty});
            chk("start",     {121'd0, o_idx_start},    {121'd0, e.start});
            chk("alloc_err", {127'd0, o_idx_alloc_err}, {127'd0, e.aerr});
            chk("free_err",  {127'd0, o_idx_free_err},  {127'd0, e.ferr});
         end
      end
   end

   initial begin
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 1, 5, 0, 0);
      step(0, 0, 1, 127, 0, 0);
      step(0, 0, 1, 127, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 9, 0, 0);
      step(0, 0, 1, 9, 1, 9);
      step(0, 0, 0, 0, 1, 9);
      step(0, 0, 1, 9, 1, 9);
      step(0, 0, 0, 0, 1, 40);
      step(0, 0, 0, 0, 0, 0);
      // Fill from empty, then over-allocate.
      step(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 128; i++) step(0, 0, 1, i, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 64);
      step(0, 0, 1, 64, 0, 0);
      // Flush and reset mid-stream with count = 50.
      step(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 50; i++) step(0, 0, 1, i, 0, 0);
      step(0, 1, 1, 3, 1, 4);
      step(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 50; i++) step(0, 0, 1, i, 0, 0);
      step(1, 0, 1, 3, 1, 4);
      step(0, 0, 0, 0, 0, 0);
      // Randomized traffic with occasional flush/reset.
      for (int i = 0; i < 3000; i++) begin
         int  ai, fi;
         bit  av, fv, fl, rs;
         ai = int'($urandom_range(0, 127));
         fi = ($urandom_range(0, 7) == 0) ? ai : int'($urandom_range(0, 127));
         av = ($urandom_range(0, 9) < 7);
         fv = ($urandom_range(0, 9) < 5);
         fl = ($urandom_range(0, 199) == 0);
         rs = ($urandom_range(0, 299) == 0);
         step(rs, fl, av, ai, fv, fi);
      end
      step(0, 0, 0, 0, 0, 0);
      @(posedge i_clk);
      #3;
      chk("drain", 128'(sb.size()), 128'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
